// File: rtl/ssm_row_stream.sv
// rtl/ssm_row_stream.sv - streaming lane-parallel SSM row engine (state update and y reduction)
module ssm_row_stream #(
  parameter int DW    = 16,
  parameter int FRAC  = 10,
  parameter int N     = 128,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DW-1:0]         dt_in,
  input  logic [DW-1:0]         dA_in,
  input  logic [DW-1:0]         x_in,
  input  logic [DW-1:0]         D_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   hprev_in,
  input  logic [LANES*DW-1:0]   B_in,
  input  logic [LANES*DW-1:0]   C_in,
  output logic                  h_valid,
  input  logic                  h_ready,
  output logic [LANES*DW-1:0]   h_out,
  output logic                  h_last,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [DW-1:0]         y_out,
  output logic                  sat_flag
);

  localparam int BEATS = N / LANES;
  localparam int ACCW  = 2*DW + $clog2(N) + 1;
  // Working width for every rescale input: wide enough for acc + D*x.
  localparam int WW    = ACCW + 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  localparam logic signed [WW-1:0] MAXV = {{(WW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(WW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, YOUT} state_t;

  state_t                 state, state_n;
  logic signed [DW-1:0]   da_r, x_r, d_r, dtx_r;
  logic [CW-1:0]          cnt;
  logic signed [ACCW-1:0] acc;
  logic                   cmd_acc, beat_acc;
  logic [LANES*DW-1:0]    hn_bus;
  logic [LANES-1:0]       hn_sat;
  logic signed [ACCW-1:0] beat_sum;
  logic [DW:0]            lane_rs;
  logic [DW:0]            dtx_rs;
  logic [DW:0]            y_rs;

  // Sign-extend a data word to the rescale working width.
  function automatic logic signed [WW-1:0] sx(input logic [DW-1:0] v);
    return {{(WW-DW){v[DW-1]}}, v};
  endfunction

  // Sign-extend a data word to the accumulator width.
  function automatic logic signed [ACCW-1:0] sxa(input logic [DW-1:0] v);
    return {{(ACCW-DW){v[DW-1]}}, v};
  endfunction

  // Floor-shift by FRAC then saturate; MSB of the result flags saturation.
  function automatic logic [DW:0] rs(input logic signed [WW-1:0] v);
    logic signed [WW-1:0] s;
    s = v >>> FRAC;
    if (s > MAXV)      return {1'b1, MAXV[DW-1:0]};
    else if (s < MINV) return {1'b1, MINV[DW-1:0]};
    else               return {1'b0, s[DW-1:0]};
  endfunction

  assign cmd_acc  = cmd_valid && cmd_ready;
  assign beat_acc = in_valid && in_ready;
  assign dtx_rs   = rs(sx(dt_in) * sx(x_in));
  assign y_rs     = rs(signed'({acc[ACCW-1], acc}) + sx(d_r) * sx(x_r));

  // Per-lane state update and this beat's contribution to the y dot product.
  always_comb begin
    hn_bus   = '0;
    hn_sat   = '0;
    beat_sum = '0;
    lane_rs  = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_rs = rs(sx(da_r) * sx(hprev_in[DW*l +: DW]) + sx(dtx_r) * sx(B_in[DW*l +: DW]));
      hn_bus[DW*l +: DW] = lane_rs[DW-1:0];
      hn_sat[l]          = lane_rs[DW];
      beat_sum           = beat_sum + sxa(C_in[DW*l +: DW]) * sxa(lane_rs[DW-1:0]);
    end
  end

  // Next-state and handshake readiness for the row sequencer.
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = RUN;
      end
      RUN: begin
        in_ready = !h_valid || h_ready;
        if (in_valid && in_ready && (cnt == LAST)) state_n = YOUT;
      end
      YOUT: begin
        if (y_valid && y_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Command latch, beat pipeline register, accumulator and y result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      da_r     <= '0;
      x_r      <= '0;
      d_r      <= '0;
      dtx_r    <= '0;
      cnt      <= '0;
      acc      <= '0;
      h_out    <= '0;
      h_valid  <= 1'b0;
      h_last   <= 1'b0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (cmd_acc) begin
        da_r     <= dA_in;
        x_r      <= x_in;
        d_r      <= D_in;
        dtx_r    <= dtx_rs[DW-1:0];
        acc      <= '0;
        cnt      <= '0;
        sat_flag <= dtx_rs[DW];
      end
      // The previous row's last h beat may still be draining while a new command lands.
      if (beat_acc) begin
        h_out   <= hn_bus;
        h_valid <= 1'b1;
        h_last  <= (cnt == LAST);
        acc     <= acc + beat_sum;
        cnt     <= cnt + 1'b1;
        if (|hn_sat) sat_flag <= 1'b1;
      end else if (h_valid && h_ready) begin
        h_valid <= 1'b0;
      end
      if (state == YOUT && !y_valid) begin
        y_out   <= y_rs[DW-1:0];
        y_valid <= 1'b1;
        if (y_rs[DW]) sat_flag <= 1'b1;
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ssm_row_stream.sv
// tb/tb_ssm_row_stream.sv - self-checking bench for ssm_row_stream (N=8, LANES=4)
module tb_ssm_row_stream;

  localparam int DW    = 16;
  localparam int FRAC  = 10;
  localparam int N     = 8;
  localparam int LANES = 4;
  localparam int BEATS = N / LANES;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [DW-1:0]       dt_in = '0, dA_in = '0, x_in = '0, D_in = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*DW-1:0] hprev_in = '0, B_in = '0, C_in = '0;
  logic                h_valid;
  logic                h_ready = 1'b1;
  logic [LANES*DW-1:0] h_out;
  logic                h_last;
  logic                y_valid;
  logic                y_ready = 1'b1;
  logic [DW-1:0]       y_out;
  logic                sat_flag;

  ssm_row_stream #(.DW(DW), .FRAC(FRAC), .N(N), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .dt_in(dt_in), .dA_in(dA_in), .x_in(x_in), .D_in(D_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .hprev_in(hprev_in), .B_in(B_in), .C_in(C_in),
    .h_valid(h_valid), .h_ready(h_ready), .h_out(h_out), .h_last(h_last),
    .y_valid(y_valid), .y_ready(y_ready), .y_out(y_out),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]  dt, da, x, d;
    logic [127:0] hp, b, c;
  } row_t;

  typedef struct packed {
    logic [15:0] dt, da, x, d, hp, b, c, eh, ey;
    logic        es;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cmd_edge = 0;
  int last_beat_edge = 0;
  int last_y_edge = 0;
  bit rand_bp = 0;
  logic [64:0] exp_h[$];
  logic [16:0] exp_y[$];
  vec_t tbl[7];

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic longint sg(logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint rsm(longint v);
    longint q;
    q = v >>> FRAC;
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    return q;
  endfunction

  function automatic bit rso(longint v);
    longint q;
    q = v >>> FRAC;
    return (q > 32767) || (q < -32768);
  endfunction

  // Whole-row reference: plain arithmetic over all N elements, no beats or lanes.
  task automatic model(input row_t r, output logic [127:0] h, output logic [15:0] y, output bit s);
    longint p, dtx, hn, acc;
    s = 1'b0;
    h = '0;
    p = sg(r.dt) * sg(r.x);
    s |= rso(p);
    dtx = rsm(p);
    acc = 0;
    for (int i = 0; i < N; i++) begin
      p = sg(r.da) * sg(r.hp[16*i +: 16]) + dtx * sg(r.b[16*i +: 16]);
      s |= rso(p);
      hn = rsm(p);
      h[16*i +: 16] = hn[15:0];
      acc += sg(r.c[16*i +: 16]) * hn;
    end
    p = acc + sg(r.d) * sg(r.x);
    s |= rso(p);
    hn = rsm(p);
    y = hn[15:0];
  endtask

  task automatic push_exp(input logic [127:0] h, input logic [15:0] y, input bit s);
    for (int b = 0; b < BEATS; b++) exp_h.push_back({(b == BEATS-1), h[b*64 +: 64]});
    exp_y.push_back({s, y});
  endtask

  function automatic row_t mk(vec_t v);
    row_t r;
    r.dt = v.dt; r.da = v.da; r.x = v.x; r.d = v.d;
    r.hp = {N{v.hp}}; r.b = {N{v.b}}; r.c = {N{v.c}};
    return r;
  endfunction

  function automatic logic [15:0] rv();
    int t;
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    t = $urandom_range(0, 4095);
    return 16'(t - 2048);
  endfunction

  function automatic row_t rand_row();
    row_t r;
    r.dt = rv(); r.da = rv(); r.x = rv(); r.d = rv();
    for (int i = 0; i < N; i++) begin
      r.hp[16*i +: 16] = rv();
      r.b[16*i +: 16]  = rv();
      r.c[16*i +: 16]  = rv();
    end
    return r;
  endfunction

  task automatic do_cmd(input row_t r);
    int k;
    dt_in = r.dt; dA_in = r.da; x_in = r.x; D_in = r.d;
    cmd_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
    chk("cmd_wait", cmd_ready, 1);
    cmd_edge = cyc + 1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_beat(input row_t r, input int b);
    int k;
    hprev_in = r.hp[b*64 +: 64];
    B_in     = r.b[b*64 +: 64];
    C_in     = r.c[b*64 +: 64];
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    chk("beat_wait", in_ready, 1);
    last_beat_edge = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int k;
    k = 0;
    @(negedge clk);
    while ((exp_h.size() != 0 || exp_y.size() != 0) && k < bound) begin @(negedge clk); k++; end
    chk("drain", (exp_h.size() == 0 && exp_y.size() == 0), 1);
    @(posedge clk); #1;
  endtask

  task automatic monitor();
    logic [64:0] eh;
    logic [16:0] ey;
    forever begin
      @(negedge clk);
      if (h_valid && h_ready) begin
        if (exp_h.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL h_extra: got %0h expected no beat", {h_last, h_out});
        end else begin
          eh = exp_h.pop_front();
          chk("h_beat", {h_last, h_out}, eh);
        end
      end
      if (y_valid && y_ready) begin
        last_y_edge = cyc + 1;
        if (exp_y.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL y_extra: got %0h expected no y", {sat_flag, y_out});
        end else begin
          ey = exp_y.pop_front();
          chk("y_sat", {sat_flag, y_out}, ey);
        end
      end
    end
  endtask

  initial begin
    row_t r, ra, rb;
    logic [127:0] eh, eha, ehb;
    logic [15:0] ey, eya, eyb;
    bit es, esa, esb;
    int c0, b1, k;

    //            dt        dA        x         D         hp        B         C         h_exp     y_exp     sat
    tbl[0] = '{16'h0400, 16'h0400, 16'h0400, 16'h0000, 16'h0000, 16'h0400, 16'h0400, 16'h0400, 16'h2000, 1'b0};
    tbl[1] = '{16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0000, 16'h0400, 16'h0000, 16'h0400, 16'h0400, 1'b0};
    tbl[2] = '{16'h0400, 16'h0200, 16'h0400, 16'h0000, 16'hFFFF, 16'h0000, 16'h0400, 16'hFFFF, 16'hFFF8, 1'b0};
    tbl[3] = '{16'h0400, 16'h7FFF, 16'h0400, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1};
    tbl[4] = '{16'h0200, 16'hFC00, 16'h0800, 16'h0400, 16'h0800, 16'h0C00, 16'hFE00, 16'h0400, 16'hF800, 1'b0};
    tbl[5] = '{16'h0400, 16'h0400, 16'h0400, 16'h0000, 16'h7C00, 16'h0000, 16'h7C00, 16'h7C00, 16'h7FFF, 1'b1};
    tbl[6] = '{16'h0400, 16'h8000, 16'h0400, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 1'b1};

    fork
      monitor();
      forever begin @(posedge clk); cyc++; end
      forever begin
        @(posedge clk); #1;
        if (rand_bp) begin
          h_ready = ($urandom_range(0, 3) != 0);
          y_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valids", {h_valid, y_valid}, 0);
    chk("rst_h_out", {h_last, h_out}, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_sat", sat_flag, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed table rows
    for (int i = 0; i < 7; i++) begin
      r = mk(tbl[i]);
      push_exp({N{tbl[i].eh}}, tbl[i].ey, tbl[i].es);
      do_cmd(r);
      chk("sat_clr", sat_flag, 0);
      do_beat(r, 0);
      do_beat(r, 1);
      wait_drain(50);
    end

    // Latency and row cost on the basic row
    r = mk(tbl[0]);
    push_exp({N{16'h0400}}, 16'h2000, 1'b0);
    do_cmd(r);
    c0 = cmd_edge;
    chk("h_idle", h_valid, 0);
    do_beat(r, 0);
    chk("h_lat", h_valid, 1);
    chk("h_first", h_out, {LANES{16'h0400}});
    do_beat(r, 1);
    b1 = last_beat_edge;
    wait_drain(50);
    chk("y_lat", last_y_edge - b1, 2);
    chk("row_cost", last_y_edge - c0 + 1, BEATS + 3);

    // h and y backpressure
    r = rand_row();
    model(r, eh, ey, es);
    push_exp(eh, ey, es);
    do_cmd(r);
    do_beat(r, 0);
    h_ready = 1'b0;
    hprev_in = r.hp[127:64]; B_in = r.b[127:64]; C_in = r.c[127:64];
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_h_valid", h_valid, 1);
      chk("bp_h_hold", h_out, eh[63:0]);
    end
    @(posedge clk); #1;
    h_ready = 1'b1;
    y_ready = 1'b0;
    do_beat(r, 1);
    k = 0;
    @(negedge clk);
    while (!y_valid && k < 20) begin @(negedge clk); k++; end
    chk("y_wait", y_valid, 1);
    for (int i = 0; i < 3; i++) begin
      chk("yh_valid", y_valid, 1);
      chk("yh_data", y_out, ey);
      chk("yh_cmd_ready", cmd_ready, 0);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    y_ready = 1'b1;
    wait_drain(50);

    // Back-to-back rows
    ra = rand_row();
    rb = rand_row();
    model(ra, eha, eya, esa);
    model(rb, ehb, eyb, esb);
    push_exp(eha, eya, esa);
    push_exp(ehb, eyb, esb);
    do_cmd(ra);
    do_beat(ra, 0);
    do_beat(ra, 1);
    do_cmd(rb);
    chk("b2b_cmd", cmd_edge - last_y_edge, 1);
    do_beat(rb, 0);
    do_beat(rb, 1);
    wait_drain(50);

    // Reset mid-row
    r = rand_row();
    h_ready = 1'b0;
    do_cmd(r);
    do_beat(r, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_valids", {h_valid, y_valid}, 0);
    chk("mid_rst_h_out", h_out, 0);
    chk("mid_rst_sat", sat_flag, 0);
    h_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_quiet", {h_valid, y_valid}, 0);
    end
    @(posedge clk); #1;
    r = mk(tbl[4]);
    push_exp({N{tbl[4].eh}}, tbl[4].ey, tbl[4].es);
    do_cmd(r);
    do_beat(r, 0);
    do_beat(r, 1);
    wait_drain(50);

    // Randomized rows under random backpressure
    rand_bp = 1;
    for (int i = 0; i < 24; i++) begin
      r = rand_row();
      model(r, eh, ey, es);
      push_exp(eh, ey, es);
      do_cmd(r);
      do_beat(r, 0);
      do_beat(r, 1);
    end
    wait_drain(500);
    rand_bp = 0;
    h_ready = 1'b1;
    y_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssm_row_stream.md
Name: ssm_row_stream

Overview:
Streaming, lane-parallel successor to the flat-bus SSM packing engine. It processes one (head, p) row of the Mamba-2 state update:
- state update: h_new[n] = dA*h_prev[n] + (dt*x)*B[n]
- output: y = sum_n C[n]*h_new[n] + D*x

It uses signed fixed point and ready/valid streams in place of whole-tensor buses. The controller issues one command per row, streams N/LANES beats of state/B/C, and collects the h_new beats and the single y.

Parameters:
DW, 16, signed fixed-point word width of all data
FRAC, 10, fractional bits (1.0 = 2^FRAC)
N, 128, state dimension per row; must be a multiple of LANES
LANES, 4, state elements processed per beat; BEATS = N/LANES (local)
ACCW, 2*DW+$clog2(N)+1, y accumulator width (local)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
cmd_valid  in  1  row command valid
cmd_ready  out  1  high only in IDLE
dt_in  in  DW  per-head dt
dA_in  in  DW  per-head dA
x_in  in  DW  x[h,p]
D_in  in  DW  per-head D
in_valid  in  1  beat valid
in_ready  out  1  beat accept
hprev_in  in  LANES*DW  h_prev lanes, lane l in bits [DW*l +: DW]
B_in  in  LANES*DW  B lanes
C_in  in  LANES*DW  C lanes
h_valid  out  1  h_new beat valid
h_ready  in  1  h_new beat accept
h_out  out  LANES*DW  h_new lanes
h_last  out  1  marks beat BEATS-1
y_valid  out  1  y valid
y_ready  in  1  y accept
y_out  out  DW  y result
sat_flag  out  1  sticky per row: any saturation occurred; cleared on cmd accept

Behaviour:
- Reset (rst==0 at a clk edge):
  - state goes to IDLE; beat counter, acc and all registers are cleared.
  - h_valid, y_valid, h_out, h_last, y_out and sat_flag are all 0.
  - Reset mid-row discards all work in progress. Nothing is emitted afterwards.
- Fixed-point rule, applied at every rescale (op "rs"):
  - take the full-precision product or sum;
  - arithmetic shift right by FRAC, i.e. floor;
  - saturate to [-2^(DW-1), 2^(DW-1)-1].
  - Any saturation sets sat_flag.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch dA, x and D; register dtx = rs(dt*x); clear acc and sat_flag; cnt=0; go to RUN.
  - in_ready=0 in IDLE.
- RUN:
  - in_ready = !h_valid || h_ready (single-stage output register; no skid).
  - On beat accept, for each lane l:
    - hn[l] = rs(dA*hprev[l] + dtx*B[l]); the sum is taken at 2*DW+1 bits before the shift.
    - h_out <= hn; h_valid <= 1; h_last <= (cnt==BEATS-1).
    - acc += sum_l C[l]*hn[l], full precision, no rescale.
    - cnt++.
  - h_valid clears on (h_valid && h_ready) with no new accept in the same cycle.
  - When the beat with cnt==BEATS-1 is accepted: go to YOUT.
- YOUT:
  - Register y_out = rs(acc + D*x); y_valid=1 the cycle after entry.
  - Hold y_out and y_valid until y_ready. On handshake: y_valid=0, go to IDLE.
  - The last h beat may still be pending while y is valid. The two handshakes are independent.
  - in_ready=0.
- Ordering and latency:
  - A new command is not accepted until y has handshaked.
  - The next row's first beat stalls until the previous h_last beat drains.
- Throughput and latency:
  - With no backpressure: 1 beat per cycle.
  - h_out valid 1 cycle after its input beat.
  - y_valid 2 cycles after the last beat is accepted.
  - Row cost: BEATS + 3 cycles including the command.
- Boundaries:
  - in_valid while in IDLE or YOUT is ignored (not accepted).
  - y_ready held high early has no effect.
  - LANES==N gives BEATS=1: h_last is high on the only beat.

Test Plan:
All cases use N=8, LANES=4 (BEATS=2), FRAC=10.
- Basic row: dA=dt=x=0x0400, D=0, h_prev=0, B=C=0x0400 on both beats, ready held high -> h_out lanes all 0x0400, h_last on beat 2, y_out=0x2000, sat_flag=0, y_valid 2 cycles after beat 2.
- D term: same as basic with D=0x0400 and C=0 -> h_out all 0x0400, y_out=0x0400.
- Floor rounding: dA=0x0200, h_prev=0xFFFF, B=0 -> every h_out lane is 0xFFFF, not 0x0000.
- Saturation: dA=h_prev=0x7FFF -> h_out=0x7FFF, sat_flag=1. The next cmd accept clears sat_flag.
- Backpressure: h_ready low 5 cycles after beat 1 -> in_ready low, h_out held stable, beat 2 accepted only after h_ready rises, no data lost. Also y_ready low 3 cycles -> y held, cmd_ready stays 0.
- Back-to-back and reset:
  - Two rows with y_ready high -> second cmd accepted the cycle after the first y handshake; outputs correct for both rows.
  - rst=0 after beat 1 -> all valids 0, cmd_ready=1 the cycle after rst returns to 1, no y emitted.
